// File: rtl/board_cell_reader.sv
// Scans a FILAS x COLUMNAS board in row-major order through a registered read port.
// It emits one (fila, columna, estado) beat per cell and reports the occupancy of the board.
// Optional feature: define BOARD_READER_SKIP_EMPTY_EN to suppress the beats for empty cells.
module board_cell_reader #(
    parameter int FILAS    = 5,
    parameter int COLUMNAS = 5,
    parameter int ESTADO_W = 2,
    localparam int FW = $clog2(FILAS),
    localparam int CW = $clog2(COLUMNAS),
    localparam int NW = $clog2(FILAS * COLUMNAS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                rd_en,
    output logic [FW-1:0]       rd_fila,
    output logic [CW-1:0]       rd_columna,
    input  logic [ESTADO_W-1:0] rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FW-1:0]       out_fila,
    output logic [CW-1:0]       out_columna,
    output logic [ESTADO_W-1:0] out_estado,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [NW-1:0]       occupied_count,
    output logic                board_full
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t        state, state_next;
    logic [FW-1:0] fila, fila_adv;
    logic [CW-1:0] columna, columna_adv;
    logic [NW-1:0] count;
    logic          last_q;
    logic          last_cell;
    logic          cell_empty;

    assign last_cell  = (fila == FW'(FILAS - 1)) && (columna == CW'(COLUMNAS - 1));
    assign cell_empty = (rd_data == '0);

    always_comb begin
        fila_adv    = fila;
        columna_adv = columna + CW'(1);
        if (columna == CW'(COLUMNAS - 1)) begin
            columna_adv = '0;
            fila_adv    = fila + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            fila           <= '0;
            columna        <= '0;
            count          <= '0;
            out_fila       <= '0;
            out_columna    <= '0;
            out_estado     <= '0;
            last_q         <= 1'b0;
            occupied_count <= '0;
            board_full     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        fila    <= '0;
                        columna <= '0;
                        count   <= '0;
                    end
                end
                WAIT: begin
                    out_estado  <= rd_data;
                    out_fila    <= fila;
                    out_columna <= columna;
                    last_q      <= last_cell;
                    if (!cell_empty) begin
                        count <= count + NW'(1);
                    end
`ifdef BOARD_READER_SKIP_EMPTY_EN
                    // Skipped cells advance here since they never reach SEND.
                    if (cell_empty && !last_cell) begin
                        fila    <= fila_adv;
                        columna <= columna_adv;
                    end
`endif
                end
                SEND: begin
                    if (out_ready && !last_cell) begin
                        fila    <= fila_adv;
                        columna <= columna_adv;
                    end
                end
                DONE: begin
                    occupied_count <= count;
                    board_full     <= (count == NW'(FILAS * COLUMNAS));
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = WAIT;
            WAIT: begin
                state_next = SEND;
`ifdef BOARD_READER_SKIP_EMPTY_EN
                if (cell_empty) state_next = last_cell ? DONE : READ;
`endif
            end
            SEND: if (out_ready) state_next = last_cell ? DONE : READ;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rd_en      = (state == READ);
    assign rd_fila    = fila;
    assign rd_columna = columna;
    assign out_valid  = (state == SEND);
    assign out_last   = out_valid && last_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_board_cell_reader.sv
// Self-checking bench for board_cell_reader: directed and random boards are compared against a
// row-major reference list of the beats each board should produce.
module tb_board_cell_reader;
    localparam int F  = 5;
    localparam int C  = 5;
    localparam int EW = 2;
    localparam int N  = F * C;
`ifdef BOARD_READER_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [EW-1:0] rd_data = '0;
    logic          rd_en, out_valid, out_last, busy, done, board_full;
    logic [2:0]    rd_fila, out_fila;
    logic [2:0]    rd_columna, out_columna;
    logic [EW-1:0] out_estado;
    logic [4:0]    occupied_count;

    board_cell_reader #(.FILAS(F), .COLUMNAS(C), .ESTADO_W(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en(rd_en), .rd_fila(rd_fila), .rd_columna(rd_columna), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_fila(out_fila),
        .out_columna(out_columna), .out_estado(out_estado), .out_last(out_last),
        .busy(busy), .done(done), .occupied_count(occupied_count), .board_full(board_full)
    );

    always #5 clk = ~clk;

    // Cell register model: registered read, data one cycle after rd_en.
    logic [EW-1:0] board [F][C];
    always @(posedge clk) if (rd_en) rd_data <= board[rd_fila][rd_columna];

    typedef struct { int f; int c; int e; bit last; } beat_t;
    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    prev_occ = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int build_expected();
        int occ = 0;
        exp_q.delete();
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < C; c++) begin
                if (board[r][c] != 0) occ++;
                if (!SKIP || board[r][c] != 0)
                    exp_q.push_back('{r, c, int'(board[r][c]), (r == F - 1 && c == C - 1)});
            end
        end
        return occ;
    endfunction

    task automatic fill_board(input int lo, input int hi);
        for (int r = 0; r < F; r++)
            for (int c = 0; c < C; c++)
                board[r][c] = EW'($urandom_range(hi, lo));
    endtask

    task automatic run_scan(input int stall_beat, input int stall_len, input int restart_beat,
                            input bit rand_ready);
        int    nb = 0, cyc = 1, nrd = 0, stall_cnt = 0, exp_occ;
        int    hf = 0, hc = 0, he = 0;
        bit    holding = 0, done_seen = 0, restarted = 0;
        exp_occ = build_expected();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done_seen && cyc < 3000) begin
            if (rd_en) begin
                nrd++;
                chk("rd_en_during_send", 32'(out_valid), 0);
            end
            if (done) begin
                done_seen = 1;
                chk("occ_held_until_done", 32'(occupied_count), prev_occ);
            end else begin
                if (out_valid && nb == stall_beat && stall_cnt < stall_len) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
                end
                start = (out_valid && nb == restart_beat && !restarted);
                if (start) restarted = 1;
                if (out_valid) begin
                    if (!holding) begin
                        holding = 1;
                        hf = int'(out_fila); hc = int'(out_columna); he = int'(out_estado);
                    end else begin
                        chk("beat_stable", {out_fila, out_columna, out_estado},
                            {3'(hf), 3'(hc), EW'(he)});
                    end
                    if (out_ready) begin
                        if (nb < exp_q.size()) begin
                            chk("beat_fila", 32'(out_fila), exp_q[nb].f);
                            chk("beat_columna", 32'(out_columna), exp_q[nb].c);
                            chk("beat_estado", 32'(out_estado), exp_q[nb].e);
                            chk("beat_last", 32'(out_last), 32'(exp_q[nb].last));
                        end else begin
                            chk("extra_beat", nb, exp_q.size());
                        end
                        nb++;
                        holding = 0;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", 32'(done_seen), 1);
        chk("beat_count", nb, exp_q.size());
        chk("read_count", nrd, N);
        if (stall_beat >= 0 && stall_beat < exp_q.size()) chk("stall_len", stall_cnt, stall_len);
        if (!rand_ready) chk("scan_cycles", cyc, 2 * N + exp_q.size() + 1 + stall_cnt);
        @(posedge clk); #1;
        chk("occupied_count", 32'(occupied_count), exp_occ);
        chk("board_full", 32'(board_full), 32'(exp_occ == N));
        for (int i = 0; i < 3; i++) begin
            chk("idle_no_done", {30'd0, busy, done}, 0);
            @(posedge clk); #1;
        end
        prev_occ = exp_occ;
    endtask

    initial begin
        int nb, guard;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outputs", {rd_en, out_valid, out_last, done, board_full}, 0);
        chk("rst_fields", {rd_fila, rd_columna, out_fila, out_columna, out_estado}, 0);
        chk("rst_occ", 32'(occupied_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Sparse board from the plan: three marks
        for (int r = 0; r < F; r++) for (int c = 0; c < C; c++) board[r][c] = '0;
        board[2][3] = 2'd1; board[0][0] = 2'd2; board[4][2] = 2'd1;
        run_scan(-1, 0, -1, 1'b0);

        // Full board
        for (int r = 0; r < F; r++) for (int c = 0; c < C; c++) board[r][c] = 2'd1;
        run_scan(-1, 0, -1, 1'b0);

        // Stall on beat 7, cell (1,2)
        fill_board(1, 3);
        run_scan(7, 10, -1, 1'b0);

        // Second start while busy is ignored
        fill_board(1, 3);
        run_scan(-1, 0, 5, 1'b0);

        // Reset mid-scan on beat 12
        fill_board(1, 3);
        nb = 0;
        guard = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        while (!(out_valid && nb == 12) && guard < 1000) begin
            if (out_valid) nb++;
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_beat12", 32'(guard < 1000), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_outputs", {rd_en, out_valid, out_last, done, board_full}, 0);
        chk("midrst_fields", {rd_fila, rd_columna, out_fila, out_columna, out_estado}, 0);
        chk("midrst_occ", 32'(occupied_count), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", {30'd0, busy, done}, 0);
        end
        prev_occ = 0;
        run_scan(-1, 0, -1, 1'b0);

        // Random boards, random backpressure
        for (int k = 0; k < 4; k++) begin
            fill_board(0, 3);
            run_scan(-1, 0, -1, 1'b1);
        end
        fill_board(0, 3);
        run_scan(-1, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_cell_reader.md
Name: board_cell_reader

Overview:
- Read-side counterpart of the board cell register. The cell register writes and validates moves by fila/columna; this block reads the board back out.
- On a start pulse it walks every cell in row-major order over a registered read port.
- It emits each cell as a (fila, columna, estado) beat on a valid/ready stream, for the display and win-check logic.
- It also reports the number of occupied cells and a board-full flag.

Parameters:
- FILAS, 5, number of board rows.
- COLUMNAS, 5, number of board columns.
- ESTADO_W, 2, cell state width; 0 = empty, non-zero = player mark.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- rd_en  out  1  read strobe to the cell register.
- rd_fila  out  $clog2(FILAS)  read row address.
- rd_columna  out  $clog2(COLUMNAS)  read column address.
- rd_data  in  ESTADO_W  cell state, valid exactly 1 cycle after rd_en.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_fila  out  $clog2(FILAS)  row of the current beat.
- out_columna  out  $clog2(COLUMNAS)  column of the current beat.
- out_estado  out  ESTADO_W  state of the current beat.
- out_last  out  1  marks the beat for cell (FILAS-1, COLUMNAS-1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at scan completion.
- occupied_count  out  $clog2(FILAS*COLUMNAS+1)  non-empty cells counted in the last scan.
- board_full  out  1  occupied_count == FILAS*COLUMNAS.

Behaviour:
- Reset:
  - State returns to IDLE.
  - All outputs are 0, including occupied_count and board_full.
  - Row/column counters are cleared to (0,0).
  - Reset takes priority over every other event, including mid-scan. It abandons any beat in flight and produces no done pulse.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - start=1 clears the internal counter and the (fila, columna) pointer, then goes to READ.
  - occupied_count and board_full hold the previous scan's result until the new scan reaches DONE.
- READ (1 cycle): rd_en=1 with rd_fila/rd_columna equal to the pointer, then go to WAIT.
- WAIT (1 cycle):
  - Register rd_data into out_estado; latch out_fila/out_columna from the pointer.
  - Increment the internal counter if rd_data != 0.
  - Go to SEND.
- SEND:
  - out_valid=1 and all beat fields are held stable until out_ready=1.
  - On handshake (out_valid & out_ready), deassert out_valid the next cycle.
  - If the beat was the last cell, go to DONE. Otherwise advance the pointer and go to READ.
  - Pointer advance: columna+1; at columna==COLUMNAS-1, wrap columna to 0 and increment fila.
- DONE (1 cycle):
  - done=1.
  - occupied_count and board_full update from the internal counter, visible the cycle after DONE.
  - Go to IDLE.
- Latency: 3 cycles per cell with out_ready held high. A full 5x5 scan is 75 cycles plus 1 DONE cycle after the start is accepted.
- start while busy is ignored (no restart, no queueing).
- out_ready high outside SEND has no effect.
- rd_en is never high outside READ. Exactly one read is issued per cell per scan.
- Pointer values never exceed FILAS-1 / COLUMNAS-1; there is no out-of-range addressing.

Optional Feature:
- Macro: BOARD_READER_SKIP_EMPTY_EN.
- Defined:
  - In WAIT, a cell with rd_data == 0 skips SEND. It advances directly to READ, or to DONE if it was the last cell.
  - Skipped cells still count as visited, so the scan still terminates with done.
  - out_last is asserted only on a beat for cell (FILAS-1, COLUMNAS-1). If that cell is empty, no beat carries out_last and done alone terminates the scan.
- Undefined: every cell is emitted as described in Behaviour.

Test Plan:
- Board with (2,3)=1, (0,0)=2, (4,2)=1, rest 0; pulse start, out_ready=1 → 25 beats in row-major order; beat 0 is (0,0,2), beat 13 is (2,3,1), beat 22 is (4,2,1); out_last only on beat 24; done 76 cycles after start; occupied_count=3; board_full=0.
- All 25 cells =1 → occupied_count=25, board_full=1.
- Hold out_ready=0 for 10 cycles on beat 7 → out_valid and fields stay constant at (1,2,x); no rd_en during the stall; the scan resumes after out_ready=1.
- Assert reset at beat 12 → next cycle all outputs 0, busy=0, no done pulse; a new start rescans from (0,0).
- Pulse start again at beat 5 → ignored; exactly 25 beats and a single done pulse.
- With BOARD_READER_SKIP_EMPTY_EN defined and the first board → exactly 3 beats (0,0,2), (2,3,1), (4,2,1); no out_last; done asserted; occupied_count=3.
